// File: rtl/spi_master_wb.sv
// spi_master_wb: Wishbone-controlled SPI master, CPOL=0/CPHA=1, MSB first
module spi_master_wb #(
  parameter int SPI_WID = 24,
  parameter int CYCLE_HALF_WAIT = 2,
  parameter int SS_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  input  logic [3:0]  wb_sel,
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        ss_L
);
  localparam int HP = 2 * CYCLE_HALF_WAIT;
  localparam int CW = $clog2((SS_WAIT > HP ? SS_WAIT : HP) + 1);
  localparam int BW = $clog2(SPI_WID + 1);
  typedef enum logic [1:0] {IDLE, SS_SETUP, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [BW-1:0] bcnt, bcnt_nx;
  logic [SPI_WID-1:0] shift, shift_nx, to_slave, from_slave, from_slave_nx;
  logic [SPI_WID:0] shift_in;
  logic sck_nx, mosi_nx, arm, ready_to_arm, finished;
  logic req, go, wr, unused_ok;
  logic [2:0] sel;
  logic [31:0] status, rdata;
  assign ready_to_arm = state == IDLE;
  assign finished = state == DONE;
  assign ss_L = ~(state == SS_SETUP || state == SHIFT);
  assign shift_in = {shift, miso};
  assign sel = wb_adr[4:2];
  assign status = {30'b0, finished, ready_to_arm};
  assign req = wb_cyc & wb_stb & ~wb_ack;
  assign go = req & ~(sel == 3'd4 & ~(ready_to_arm | finished));
  assign wr = go & wb_we & (wb_sel == 4'hf);
  assign rdata = sel == 3'd0 ? 32'(from_slave) :
                 sel == 3'd1 ? {31'b0, arm} :
                 (sel == 3'd2 || sel == 3'd4) ? status :
                 sel == 3'd3 ? 32'(to_slave) : 32'b0;
  assign unused_ok = ^{wb_adr[31:5], wb_adr[1:0], wb_dat_w};
  // Bus side: ack handshake, read data capture and control registers
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      wb_ack <= 1'b0;
      wb_dat_r <= 32'b0;
      arm <= 1'b0;
      to_slave <= '0;
    end else begin
      wb_ack <= wb_cyc & (wb_ack | go);
      if (go & ~wb_we) wb_dat_r <= rdata;
      if (wr && sel == 3'd1) arm <= wb_dat_w[0];
      if (wr && sel == 3'd3 && ready_to_arm) to_slave <= wb_dat_w[SPI_WID-1:0];
    end
  end
  // Transfer sequencer: next state plus next values of counters, shifter and SPI pins
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    bcnt_nx = bcnt;
    shift_nx = shift;
    from_slave_nx = from_slave;
    sck_nx = sck;
    mosi_nx = mosi;
    case (state)
      IDLE: begin
        if (arm) begin
          state_nx = SS_SETUP;
          cnt_nx = '0;
          shift_nx = to_slave;
          sck_nx = 1'b0;
          mosi_nx = 1'b0;
        end
      end
      SS_SETUP: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(SS_WAIT - 1)) begin
          state_nx = SHIFT;
          cnt_nx = '0;
          bcnt_nx = '0;
          sck_nx = 1'b1;
          mosi_nx = shift[SPI_WID-1];
        end
      end
      SHIFT: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(CYCLE_HALF_WAIT - 1)) begin
          sck_nx = 1'b0;
          shift_nx = shift_in[SPI_WID-1:0];
        end
        if (cnt == CW'(HP - 1)) begin
          cnt_nx = '0;
          if (bcnt == BW'(SPI_WID - 1)) begin
            state_nx = DONE;
            from_slave_nx = shift;
            mosi_nx = 1'b0;
          end else begin
            bcnt_nx = bcnt + 1'b1;
            sck_nx = 1'b1;
            mosi_nx = shift[SPI_WID-1];
          end
        end
      end
      DONE: state_nx = arm ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Sequencer registers; reset aborts any transfer without touching from_slave beyond clearing it
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      shift <= '0;
      from_slave <= '0;
      sck <= 1'b0;
      mosi <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bcnt <= bcnt_nx;
      shift <= shift_nx;
      from_slave <= from_slave_nx;
      sck <= sck_nx;
      mosi <= mosi_nx;
    end
  end
endmodule

// File: tb/tb_spi_master_wb.sv
// tb_spi_master_wb: scoreboard bench for the Wishbone SPI master
module tb_spi_master_wb;
  logic clk = 1'b0;
  logic rst_L = 1'b1;
  logic wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_adr = 32'b0, wb_dat_w = 32'b0;
  logic [3:0] wb_sel = 4'b0;
  logic [31:0] wb_dat_r;
  logic wb_ack, sck, mosi, miso, ss_L;
  logic inv = 1'b0;
  int passed = 0, total = 0, last_wait = 0;
  logic [31:0] exp_q[$];
  bit rd_q[$];
  string nm_q[$];
  logic [31:0] spi_q[$];
  logic [31:0] m_e;
  bit m_r;
  string m_n;
  bit ack_q = 1'b0;
  int low = 0, pulses = 0;
  logic [31:0] word = 32'b0;
  logic sck_q = 1'b0;

  assign miso = inv ? ~mosi : mosi;
  always #5 clk = ~clk;

  spi_master_wb #(.SPI_WID(24), .CYCLE_HALF_WAIT(2), .SS_WAIT(3)) dut (
    .clk(clk), .rst_L(rst_L), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_dat_r(wb_dat_r),
    .wb_ack(wb_ack), .sck(sck), .mosi(mosi), .miso(miso), .ss_L(ss_L)
  );

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
  endfunction

  task automatic wb(input bit we, input logic [31:0] adr, input logic [31:0] d,
                    input logic [3:0] s, input string n);
    exp_q.push_back(d);
    rd_q.push_back(!we);
    nm_q.push_back(n);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr;
    wb_dat_w = we ? d : 32'b0; wb_sel = s;
    last_wait = 0;
    @(negedge clk);
    while (!wb_ack && last_wait < 300) begin
      last_wait++;
      @(negedge clk);
    end
    if (!wb_ack) begin
      total++;
      $display("FAIL %s: no ack after %0d cycles, ack required", n, last_wait);
      void'(exp_q.pop_back());
      void'(rd_q.pop_back());
      void'(nm_q.pop_back());
    end
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hf);
    wb(1'b1, a, d, s, "write");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    wb(1'b0, a, e, 4'hf, n);
  endtask

  // Bus monitor: each new ack retires the oldest expected transaction
  always @(negedge clk) begin
    if (wb_ack && !ack_q) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL wb_unexpected_ack: got ack, expected none");
      end else begin
        m_e = exp_q.pop_front();
        m_r = rd_q.pop_front();
        m_n = nm_q.pop_front();
        if (m_r) chk(m_n, wb_dat_r, m_e);
      end
    end
    ack_q = wb_ack;
  end

  // SPI monitor: collects mosi on sck rises and checks each completed select window
  always @(negedge clk) begin
    if (!rst_L) begin
      low = 0; pulses = 0; word = 32'b0;
    end else if (!ss_L) begin
      low++;
      if (sck && !sck_q) begin
        pulses++;
        word = {word[30:0], mosi};
      end
    end else if (low != 0) begin
      if (spi_q.size() == 0) begin
        total++;
        $display("FAIL spi_unexpected: got transfer 0x%0h, expected none", word);
      end else begin
        chk("spi_mosi", word, spi_q.pop_front());
        chk("spi_ss_low", 32'(low), 32'd99);
        chk("spi_pulses", 32'(pulses), 32'd24);
      end
      low = 0; pulses = 0; word = 32'b0;
    end
    sck_q = sck;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, finish required");
    $fatal(1);
  end

  initial begin
    #1 rst_L = 1'b0;
    #2;
    chk("rst_ss_L", 32'(ss_L), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_ack", 32'(wb_ack), 32'd0);
    chk("rst_dat_r", wb_dat_r, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_L = 1'b1;
    @(posedge clk); #1;
    rd(32'h8, 32'h1, "status_idle");
    rd(32'h0, 32'h0, "from_rst");
    rd(32'h4, 32'h0, "arm_rst");
    rd(32'hC, 32'h0, "to_rst");
    wr(32'hC, 32'hA5F00F);
    rd(32'hC, 32'hA5F00F, "to_readback");
    spi_q.push_back(32'hA5F00F);
    wr(32'h4, 32'h1);
    rd(32'h10, 32'h2, "blk_done");
    chk("blk_wait_range", {31'b0, (last_wait >= 95 && last_wait <= 101)}, 32'd1);
    rd(32'h0, 32'hA5F00F, "from_loopback");
    rd(32'h8, 32'h2, "status_done");
    rd(32'h4, 32'h1, "arm_readback");
    wr(32'h4, 32'h0);
    rd(32'h8, 32'h1, "status_idle2");
    inv = 1'b1;
    wr(32'hC, 32'h3C0FF1);
    spi_q.push_back(32'h3C0FF1);
    wr(32'h4, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    chk("ss_active", 32'(ss_L), 32'd0);
    wr(32'hC, 32'h123456);
    rd(32'hC, 32'h3C0FF1, "to_busy_write");
    wr(32'h4, 32'h0);
    rd(32'h10, 32'h2, "blk_arm_cleared");
    rd(32'h0, 32'hC3F00E, "from_inverted");
    rd(32'h8, 32'h1, "status_auto_idle");
    inv = 1'b0;
    spi_q.push_back(32'h3C0FF1);
    wr(32'h4, 32'h1);
    rd(32'h10, 32'h2, "blk_held");
    repeat (150) @(posedge clk);
    #1;
    rd(32'h8, 32'h2, "status_held");
    rd(32'h0, 32'h3C0FF1, "from_held");
    wr(32'h4, 32'h0);
    rd(32'h8, 32'h1, "status_released");
    wr(32'h4, 32'h1, 4'b0001);
    rd(32'h4, 32'h0, "arm_partial_sel");
    wr(32'hC, 32'h0, 4'b0011);
    rd(32'hC, 32'h3C0FF1, "to_partial_sel");
    rd(32'h18, 32'h0, "unmapped_18");
    wr(32'h18, 32'hFFFFFFFF);
    rd(32'h1C, 32'h0, "unmapped_1c");
    rd(32'h8, 32'h1, "status_no_arm");
    rd(32'hFFFFFF28, 32'h1, "status_alias");
    chk("no_transfer", 32'(ss_L), 32'd1);
    wr(32'hC, 32'hFFFFFF);
    wr(32'h4, 32'h1);
    for (int i = 0; i < 40 && !(sck && !ss_L); i++) @(negedge clk);
    chk("pre_rst_sck", 32'(sck), 32'd1);
    #2 rst_L = 1'b0;
    #1;
    chk("abort_ss_L", 32'(ss_L), 32'd1);
    chk("abort_sck", 32'(sck), 32'd0);
    chk("abort_mosi", 32'(mosi), 32'd0);
    chk("abort_dat_r", wb_dat_r, 32'd0);
    repeat (3) @(negedge clk);
    rst_L = 1'b1;
    @(posedge clk); #1;
    rd(32'h0, 32'h0, "from_after_rst");
    rd(32'h8, 32'h1, "status_after_rst");
    rd(32'h4, 32'h0, "arm_after_rst");
    rd(32'hC, 32'h0, "to_after_rst");
    repeat (5) @(posedge clk);
    chk("spi_queue_empty", 32'(spi_q.size()), 32'd0);
    chk("wb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
